// File: rtl/tnoc_pkg.sv
// tnoc shared types for the VC credit transmitter.
// Arbiter state encoding and credit counter sizing.
package tnoc_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } tnoc_arb_state_e;

    function automatic int tnoc_credit_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/tnoc_credit_counter.sv
// tnoc per-VC credit counter.
// Starts full at DEPTH; flags a sticky error on return overflow.
module tnoc_credit_counter
    import tnoc_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CW    = tnoc_credit_width(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clear,
    input  logic          i_send,
    input  logic          i_return,
    output logic [CW-1:0] o_credit,
    output logic          o_error
);

    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [CW-1:0] r_credit;
    logic          r_error;

    // Credit bookkeeping; a send and a return together cancel out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_credit <= FULL;
            r_error  <= 1'b0;
        end else if (i_clear) begin
            r_credit <= FULL;
            r_error  <= 1'b0;
        end else begin
            unique case ({i_send, i_return})
                2'b10: r_credit <= r_credit - CW'(1);
                2'b01: begin
                    if (r_credit == FULL) begin
                        r_error <= 1'b1;
                    end else begin
                        r_credit <= r_credit + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_credit = r_credit;
    assign o_error  = r_error;

endmodule

// File: rtl/tnoc_vc_credit_tx.sv
// tnoc credit-based VC transmitter.
// Packet-locked round-robin arbiter feeding a registered link stage.
module tnoc_vc_credit_tx
    import tnoc_pkg::*;
#(
    parameter int CHANNELS   = 2,
    parameter int DEPTH      = 8,
    parameter int FLIT_WIDTH = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_clear,
    input  logic [CHANNELS-1:0]            i_valid,
    output logic [CHANNELS-1:0]            o_ready,
    input  logic [CHANNELS*FLIT_WIDTH-1:0] i_data,
    input  logic [CHANNELS-1:0]            i_tail,
    input  logic [CHANNELS-1:0]            i_credit_return,
    output logic                           o_valid,
    output logic [CHANNELS-1:0]            o_vc,
    output logic [FLIT_WIDTH-1:0]          o_data,
    output logic                           o_tail,
    output logic [CHANNELS-1:0]            o_credit_empty,
    output logic                           o_credit_error
);

    localparam int CW = tnoc_credit_width(DEPTH);
    localparam int IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [CW-1:0]         w_credit [CHANNELS];
    logic [CHANNELS-1:0]   w_has_credit;
    logic [CHANNELS-1:0]   w_cnt_err;
    logic [CHANNELS-1:0]   w_elig;
    logic [CHANNELS-1:0]   w_rot;
    logic [CHANNELS-1:0]   w_pick;
    logic [CHANNELS-1:0]   w_idle_grant;
    logic [CHANNELS-1:0]   w_lock_oh;
    logic [CHANNELS-1:0]   w_grant;
    logic [CHANNELS-1:0]   w_xfer;
    logic                  w_xfer_any;
    logic                  w_xfer_tail;
    logic [IW-1:0]         w_xfer_idx;
    logic [IW-1:0]         w_ptr_next;
    logic [FLIT_WIDTH-1:0] w_xfer_data;

    tnoc_arb_state_e       r_state;
    logic [IW-1:0]         r_lock_vc;
    logic [IW-1:0]         r_ptr;

    logic                  r_valid;
    logic [CHANNELS-1:0]   r_vc;
    logic [FLIT_WIDTH-1:0] r_data;
    logic                  r_tail;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_cnt
        tnoc_credit_counter #(
            .DEPTH (DEPTH),
            .CW    (CW)
        ) u_cnt (
            .clk      (clk),
            .rst      (rst),
            .i_clear  (i_clear),
            .i_send   (w_xfer[g]),
            .i_return (i_credit_return[g]),
            .o_credit (w_credit[g]),
            .o_error  (w_cnt_err[g])
        );
        assign w_has_credit[g] = (w_credit[g] != '0);
    end

    assign w_elig = i_valid & w_has_credit;

    // Rotate eligibility so bit k is VC (ptr+k) mod CHANNELS.
    always_comb begin
        w_rot = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            for (int j = 0; j < CHANNELS; j++) begin
                if ((int'(r_ptr) + k == j) ||
                    (int'(r_ptr) + k == j + CHANNELS)) begin
                    w_rot[k] = w_elig[j];
                end
            end
        end
    end

    assign w_pick = w_rot & (~w_rot + CHANNELS'(1));

    // Rotate the winning bit back into VC numbering.
    always_comb begin
        w_idle_grant = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            for (int j = 0; j < CHANNELS; j++) begin
                if ((int'(r_ptr) + k == j) ||
                    (int'(r_ptr) + k == j + CHANNELS)) begin
                    w_idle_grant[j] = w_pick[k];
                end
            end
        end
    end

    assign w_lock_oh = CHANNELS'(1) << r_lock_vc;

    // Grant: round-robin winner when idle, locked VC gated by credit.
    always_comb begin
        w_grant = '0;
        unique case (r_state)
            ARB_IDLE:   w_grant = w_idle_grant;
            ARB_LOCKED: w_grant = w_lock_oh & w_has_credit;
            default:    w_grant = '0;
        endcase
    end

    assign o_ready     = w_grant;
    assign w_xfer      = i_valid & w_grant;
    assign w_xfer_any  = |w_xfer;
    assign w_xfer_tail = |(w_xfer & i_tail);

    // Index and payload of the (single) transferring VC.
    always_comb begin
        w_xfer_idx  = '0;
        w_xfer_data = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (w_xfer[k]) begin
                w_xfer_idx = IW'(k);
            end
            w_xfer_data = w_xfer_data |
                (i_data[k*FLIT_WIDTH +: FLIT_WIDTH] &
                 {FLIT_WIDTH{w_xfer[k]}});
        end
    end

    assign w_ptr_next = (w_xfer_idx == IW'(CHANNELS - 1)) ?
                        '0 : w_xfer_idx + IW'(1);

    // Arbiter state: lock on a non-tail head, release on tail.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ARB_IDLE;
            r_lock_vc <= '0;
            r_ptr     <= '0;
        end else if (i_clear) begin
            r_state   <= ARB_IDLE;
            r_lock_vc <= '0;
            r_ptr     <= '0;
        end else if (w_xfer_any) begin
            if (w_xfer_tail) begin
                r_state <= ARB_IDLE;
                r_ptr   <= w_ptr_next;
            end else begin
                r_state   <= ARB_LOCKED;
                r_lock_vc <= w_xfer_idx;
            end
        end
    end

    // Link register: one cycle after the transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_vc    <= '0;
            r_data  <= '0;
            r_tail  <= 1'b0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
            r_vc    <= '0;
            r_data  <= '0;
            r_tail  <= 1'b0;
        end else begin
            r_valid <= w_xfer_any;
            r_vc    <= w_xfer;
            r_data  <= w_xfer_data;
            r_tail  <= w_xfer_tail;
        end
    end

    assign o_valid        = r_valid;
    assign o_vc           = r_vc;
    assign o_data         = r_data;
    assign o_tail         = r_tail;
    assign o_credit_empty = ~w_has_credit;
    assign o_credit_error = |w_cnt_err;

endmodule

// File: tb/tb_tnoc_vc_credit_tx.sv
// Bench for tnoc_vc_credit_tx: directed scenarios plus random traffic
// against a packet-level reference model and a link scoreboard.
module tb_tnoc_vc_credit_tx;

    localparam int CH    = 2;
    localparam int DEPTH = 8;
    localparam int FW    = 64;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             i_clear = 1'b0;
    logic [CH-1:0]    i_valid = '0;
    logic [CH-1:0]    o_ready;
    logic [CH*FW-1:0] i_data = '0;
    logic [CH-1:0]    i_tail = '0;
    logic [CH-1:0]    i_credit_return = '0;
    logic             o_valid;
    logic [CH-1:0]    o_vc;
    logic [FW-1:0]    o_data;
    logic             o_tail;
    logic [CH-1:0]    o_credit_empty;
    logic             o_credit_error;

    tnoc_vc_credit_tx #(
        .CHANNELS   (CH),
        .DEPTH      (DEPTH),
        .FLIT_WIDTH (FW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .i_clear         (i_clear),
        .i_valid         (i_valid),
        .o_ready         (o_ready),
        .i_data          (i_data),
        .i_tail          (i_tail),
        .i_credit_return (i_credit_return),
        .o_valid         (o_valid),
        .o_vc            (o_vc),
        .o_data          (o_data),
        .o_tail          (o_tail),
        .o_credit_empty  (o_credit_empty),
        .o_credit_error  (o_credit_error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          v;
        logic [CH-1:0] vc;
        logic [FW-1:0] data;
        logic          t;
    } exp_t;

    exp_t          sb[$];
    logic [CH-1:0] link_log[$];
    int            n_tests = 0;
    int            n_fail  = 0;

    // reference model: credits, packet lock (-1 = none), rr pointer
    int            m_cred[CH];
    int            m_lock;
    int            m_ptr;
    logic          m_err;

    // per-VC packet sources
    int            src_left[CH];
    logic [FW-1:0] src_data[CH];

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic bitv(input logic [CH-1:0] x, input int v);
        logic [CH-1:0] t;
        t = x >> v;
        return t[0];
    endfunction

    function automatic logic [FW-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic model_reset();
        for (int v = 0; v < CH; v++) begin
            m_cred[v]   = DEPTH;
            src_left[v] = 0;
        end
        m_lock = -1;
        m_ptr  = 0;
        m_err  = 1'b0;
    endtask

    function automatic logic [CH-1:0] model_ready(input logic [CH-1:0] vld);
        logic [CH-1:0] r;
        bit            found;
        int            j;
        r     = '0;
        found = 0;
        if (m_lock >= 0) begin
            if (m_cred[m_lock] > 0) r = CH'(1) << m_lock;
        end else begin
            for (int k = 0; k < CH; k++) begin
                j = (m_ptr + k) % CH;
                if (!found && bitv(vld, j) && m_cred[j] > 0) begin
                    r     = CH'(1) << j;
                    found = 1;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [CH-1:0] model_empty();
        logic [CH-1:0] e;
        e = '0;
        for (int v = 0; v < CH; v++)
            if (m_cred[v] == 0) e = e | (CH'(1) << v);
        return e;
    endfunction

    // One clock of stimulus: drive, check combinational outputs against
    // the model, queue the expected link flit, advance the model.
    task automatic step(input logic clr, input logic [CH-1:0] want,
                        input logic [CH-1:0] ret, input int len);
        logic [CH-1:0]    sv, st, er, x;
        logic [CH*FW-1:0] pk, tmp;
        exp_t             e;
        sv = '0;
        st = '0;
        pk = '0;
        for (int v = 0; v < CH; v++) begin
            if (bitv(want, v) && src_left[v] == 0 && !clr) begin
                src_left[v] = len;
                src_data[v] = rnd64();
            end
            if (bitv(want, v) && src_left[v] > 0 && !clr)
                sv = sv | (CH'(1) << v);
            if (src_left[v] == 1)
                st = st | (CH'(1) << v);
            tmp = (CH*FW)'(src_data[v]);
            pk  = pk | (tmp << (v * FW));
        end
        @(negedge clk);
        i_valid         = sv;
        i_tail          = st;
        i_data          = pk;
        i_credit_return = ret;
        i_clear         = clr;
        #1;
        er = model_ready(sv);
        check("o_ready", o_ready, er);
        check("o_credit_empty", o_credit_empty, model_empty());
        check("o_credit_error", o_credit_error, m_err);
        x = sv & er;
        e = '0;
        if (clr) begin
            model_reset();
        end else begin
            for (int v = 0; v < CH; v++) begin
                if (bitv(x, v)) begin
                    e.v    = 1'b1;
                    e.vc   = CH'(1) << v;
                    e.data = src_data[v];
                    e.t    = (src_left[v] == 1);
                    if (src_left[v] == 1) begin
                        m_lock = -1;
                        m_ptr  = (v + 1) % CH;
                    end else begin
                        m_lock = v;
                    end
                    src_left[v]--;
                    src_data[v] = rnd64();
                end
                if (bitv(x, v) && !bitv(ret, v)) begin
                    m_cred[v]--;
                end else if (bitv(ret, v) && !bitv(x, v)) begin
                    if (m_cred[v] == DEPTH) m_err = 1'b1;
                    else m_cred[v]++;
                end
            end
        end
        sb.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst             = 1'b1;
        i_valid         = '0;
        i_tail          = '0;
        i_credit_return = '0;
        i_clear         = 1'b0;
        i_data          = '0;
        sb.delete();
        link_log.delete();
        model_reset();
        #1;
        check("rst_o_valid", o_valid, 0);
        check("rst_o_vc", o_vc, 0);
        check("rst_o_data", o_data, 0);
        check("rst_o_tail", o_tail, 0);
        check("rst_o_credit_error", o_credit_error, 0);
        check("rst_o_credit_empty", o_credit_empty, 0);
        check("rst_o_ready", o_ready, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Link monitor: one scoreboard entry per stepped cycle.
    always @(posedge clk) begin
        exp_t me;
        #1;
        if (sb.size() > 0) begin
            me = sb.pop_front();
            if (me.v) begin
                check("link_valid", o_valid, 1);
                check("link_vc", o_vc, me.vc);
                check("link_data", o_data, me.data);
                check("link_tail", o_tail, me.t);
            end else begin
                check("link_idle", o_valid, 0);
            end
            if (o_valid) link_log.push_back(o_vc);
        end
    end

    initial begin
        logic [CH-1:0] want, ret;
        logic [CH-1:0] order [9];

        // eight single-flit packets exhaust VC0 credit
        do_reset();
        repeat (8) step(1'b0, 2'b01, 2'b00, 1);
        step(1'b0, 2'b01, 2'b00, 1);
        check("t1_ready_held", o_ready[0], 0);
        check("t1_empty0", o_credit_empty[0], 1);
        check("t1_link_count", link_log.size(), 8);

        // competing 3-flit packets alternate without interleave
        do_reset();
        repeat (9) step(1'b0, 2'b11, 2'b00, 3);
        step(1'b0, 2'b00, 2'b00, 1);
        order = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10,
                  2'b01, 2'b01, 2'b01};
        check("t2_link_count", link_log.size(), 9);
        for (int i = 0; i < 9 && i < link_log.size(); i++)
            check("t2_link_order", link_log[i], order[i]);

        // VC1 runs dry mid-packet, stays locked, resumes after return
        do_reset();
        repeat (8) step(1'b0, 2'b10, 2'b00, 12);
        repeat (3) step(1'b0, 2'b11, 2'b00, 2);
        check("t3_stall", o_ready, 2'b00);
        step(1'b0, 2'b11, 2'b10, 2);
        step(1'b0, 2'b11, 2'b00, 2);
        check("t3_resume", o_ready, 2'b10);

        // simultaneous send and return on VC0 at credit 5
        do_reset();
        repeat (3) step(1'b0, 2'b01, 2'b00, 1);
        step(1'b0, 2'b01, 2'b01, 1);
        repeat (5) step(1'b0, 2'b01, 2'b00, 1);
        check("t4_not_empty", o_credit_empty[0], 0);
        step(1'b0, 2'b00, 2'b00, 1);
        check("t4_empty", o_credit_empty[0], 1);

        // overflow return on VC1 is sticky until clear
        do_reset();
        step(1'b0, 2'b00, 2'b10, 1);
        step(1'b0, 2'b00, 2'b00, 1);
        check("t5_err_set", o_credit_error, 1);
        repeat (8) step(1'b0, 2'b10, 2'b00, 1);
        step(1'b0, 2'b00, 2'b00, 1);
        check("t5_cred8_empty", o_credit_empty[1], 1);
        check("t5_err_hold", o_credit_error, 1);
        step(1'b1, 2'b00, 2'b00, 1);
        step(1'b0, 2'b00, 2'b00, 1);
        check("t5_err_clr", o_credit_error, 0);
        check("t5_clr_credit", o_credit_empty, 2'b00);

        // reset mid-packet drops the lock
        do_reset();
        repeat (2) step(1'b0, 2'b01, 2'b00, 4);
        do_reset();
        step(1'b0, 2'b10, 2'b00, 1);
        check("t6_other_vc", o_ready, 2'b10);

        // randomized traffic
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            want = CH'($urandom);
            ret  = '0;
            for (int v = 0; v < CH; v++) begin
                if ((m_cred[v] < DEPTH && $urandom_range(0, 2) == 0) ||
                    $urandom_range(0, 399) == 0)
                    ret = ret | (CH'(1) << v);
            end
            if ($urandom_range(0, 999) == 0)
                do_reset();
            step($urandom_range(0, 249) == 0, want, ret,
                 $urandom_range(1, 4));
        end
        step(1'b0, 2'b00, 2'b00, 1);
        @(negedge clk);
        check("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
